// File: rtl/seq_adder_window_ctrl.sv
// seq_adder_window_ctrl: sequencing controller for a windowed past-sequence adder
// Credit-gated sample intake, full-window result tagging and an FWFT result FIFO.
module seq_adder_window_ctrl #(
    parameter int data_width = 10,
    parameter int N = 3,
    parameter int ADDER_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    input  logic                  flush,
    output logic [data_width-1:0] adder_inp,
    output logic                  adder_en,
    output logic                  adder_clr,
    input  logic [data_width-1:0] adder_outp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic                  busy
);
    localparam int DEPTH = ADDER_LAT + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + ADDER_LAT + 2);
    localparam logic [N:0] LAST = {1'b0, {N{1'b1}}};

    typedef enum logic [1:0] {CLEAR, FILL, RUN, DRAIN} state_t;

    state_t                state, state_nx;
    logic [N:0]            fill_cnt;
    logic [ADDER_LAT-1:0]  tags;
    logic [data_width-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         occ, inflight, used;
    logic                  accept, full_tag, will_full, push, pop, active;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ADDER_LAT; i++) inflight = inflight + CW'(tags[i]);
    end

    assign push      = tags[ADDER_LAT-1];
    assign out_valid = occ != '0;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    // A pop this cycle frees a slot before any newly tagged sum can land.
    assign used      = occ + inflight - CW'(pop);
    assign active    = (state == FILL) | (state == RUN);
    assign will_full = (state == RUN) | (fill_cnt == LAST);
    assign in_ready  = rst_n & ~flush & active & (~will_full | (used < CW'(DEPTH)));
    assign accept    = in_valid & in_ready;
    assign full_tag  = accept & will_full;
    assign adder_inp = in_data;
    assign adder_en  = accept;
    assign adder_clr = ~rst_n | (state == CLEAR);
    assign busy      = ~active | (tags != '0) | out_valid;

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR: state_nx = FILL;
            FILL:  state_nx = flush ? DRAIN : (accept && fill_cnt == LAST) ? RUN : FILL;
            RUN:   state_nx = flush ? DRAIN : RUN;
            DRAIN: state_nx = (tags == '0) ? CLEAR : DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            fill_cnt <= '0;
            tags     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (push && !pop) assert (occ < CW'(DEPTH));
            state    <= state_nx;
            fill_cnt <= (state == CLEAR) ? '0 : (state == FILL && accept) ? fill_cnt + 1'b1 : fill_cnt;
            tags     <= (tags << 1) | ADDER_LAT'(full_tag);
            wr_ptr   <= push ? inc(wr_ptr) : wr_ptr;
            rd_ptr   <= pop ? inc(rd_ptr) : rd_ptr;
            occ      <= occ + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= adder_outp;
    end
endmodule
